// File: rtl/mem_rd_ctrl.sv
// Read-and-compute launch responder: issues SRAM row reads and tracks them through the
// SRAM/array latency. Optional perf counters are enabled by defining MEM_RD_PERF_CNT_EN.
module mem_rd_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned ARRAY_LAT  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] num_row,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  stall,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   output logic                  sys_in_valid,
   output logic                  sys_done,
   output logic                  sys_last,
   output logic                  busy
`ifdef MEM_RD_PERF_CNT_EN
   ,
   output logic [31:0]           perf_cycles,
   output logic [15:0]           perf_stalls
`endif
);

   localparam logic [DATA_WIDTH-1:0] One = DATA_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StZero} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] num_row_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [DATA_WIDTH-1:0] idx_q;
   logic [DATA_WIDTH-1:0] done_cnt_q;
   logic [MEM_LAT-1:0]    mem_pipe_q;
   logic [ARRAY_LAT-1:0]  arr_pipe_q;

   logic [MEM_LAT:0]      mem_chain;
   logic [ARRAY_LAT:0]    arr_chain;
   logic                  done_in;
   logic                  accept;

   assign mem_chain    = {mem_pipe_q, mem_rd_en};
   assign arr_chain    = {arr_pipe_q, sys_in_valid};
   assign sys_in_valid = mem_pipe_q[MEM_LAT-1];
   assign sys_done     = arr_pipe_q[ARRAY_LAT-1];
   // Row that becomes sys_done on the next edge; lets sys_last register alongside it.
   assign done_in      = arr_chain[ARRAY_LAT-1];
   assign accept       = (state_q == StIdle) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         num_row_q   <= '0;
         base_q      <= '0;
         idx_q       <= '0;
         done_cnt_q  <= '0;
         mem_pipe_q  <= '0;
         arr_pipe_q  <= '0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         sys_last    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         mem_pipe_q <= mem_chain[MEM_LAT-1:0];
         arr_pipe_q <= arr_chain[ARRAY_LAT-1:0];
         mem_rd_en  <= 1'b0;
         sys_last   <= 1'b0;
         if (state_q != StIdle && done_in) begin
            done_cnt_q <= done_cnt_q + One;
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_row == '0) begin
                     sys_last <= 1'b1;
                     state_q  <= StZero;
                  end else begin
                     num_row_q  <= num_row;
                     base_q     <= base_addr;
                     done_cnt_q <= '0;
                     if (!stall) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= base_addr;
                        idx_q       <= One;
                        state_q     <= (num_row == One) ? StDrain : StIssue;
                     end else begin
                        idx_q   <= '0;
                        state_q <= StIssue;
                     end
                  end
               end
            end
            StIssue: begin
               if (!stall) begin
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= base_q + ADDR_WIDTH'(idx_q);
                  idx_q       <= idx_q + One;
                  if (idx_q == num_row_q - One) begin
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (done_in && done_cnt_q == num_row_q - One) begin
                  sys_last <= 1'b1;
               end
               if (sys_last) begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StZero: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef MEM_RD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else if (accept) begin
         perf_cycles <= 32'd1;
         perf_stalls <= '0;
      end else if (state_q != StIdle) begin
         if (perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
         end
         if (state_q == StIssue && stall && perf_stalls != '1) begin
            perf_stalls <= perf_stalls + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed, table-driven bench for mem_rd_ctrl (MEM_LAT=2, ARRAY_LAT=16).
// Cycle 0 of each run is the cycle start is held high; stall_mask bit k gates issue in cycle k+1.
module tb_mem_rd_ctrl;
   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 8;
   localparam int unsigned ML   = 2;
   localparam int unsigned AL   = 16;
   localparam int          NCYC = 48;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic [DW-1:0] num_row = '0;
   logic [AW-1:0] base_addr = '0;
   logic          mem_rd_en, sys_in_valid, sys_done, sys_last, busy;
   logic [AW-1:0] mem_rd_addr;
`ifdef MEM_RD_PERF_CNT_EN
   logic [31:0]   perf_cycles;
   logic [15:0]   perf_stalls;
`endif

   mem_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(ML), .ARRAY_LAT(AL)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_row     (num_row),
      .base_addr   (base_addr),
      .stall       (stall),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .sys_in_valid(sys_in_valid),
      .sys_done    (sys_done),
      .sys_last    (sys_last),
      .busy        (busy)
`ifdef MEM_RD_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles),
      .perf_stalls (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] num_row;
      logic [AW-1:0] base;
      logic [63:0]   stall_mask;
      logic [63:0]   exp_rd;
      logic [63:0]   exp_done;
      int            exp_last;
      int            exp_busy;
   } vec_t;

   vec_t        vecs[6];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [63:0] rd_m, vld_m, done_m, last_m, busy_m;
   int          addr_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int issued;
      issued = 0;
      rd_m = '0; vld_m = '0; done_m = '0; last_m = '0; busy_m = '0; addr_err = 0;
      for (int k = 0; k < NCYC; k++) begin
         start     = (k == 0);
         num_row   = v.num_row;
         base_addr = v.base;
         stall     = v.stall_mask[k];
         rd_m[k]   = mem_rd_en;
         vld_m[k]  = sys_in_valid;
         done_m[k] = sys_done;
         last_m[k] = sys_last;
         busy_m[k] = busy;
         if (mem_rd_en === 1'b1) begin
            if (mem_rd_addr !== AW'(int'(v.base) + issued)) addr_err++;
            issued++;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      stall = 1'b0;
   endtask

   initial begin
      logic [63:0] exp_b;
      logic [AW-1:0] addr3, addr23;

      vecs[0] = '{16'd4, 8'h10, 64'h0, 64'h1E, 64'h780000, 22, 22};
      vecs[1] = '{16'd3, 8'h20, 64'h2, 64'h1A, 64'h680000, 22, 22};
      vecs[2] = '{16'd0, 8'h33, 64'h0, 64'h0,  64'h0,       1,  1};
      vecs[3] = '{16'd3, 8'hFE, 64'h0, 64'hE,  64'h380000, 21, 21};
      vecs[4] = '{16'd1, 8'h80, 64'h0, 64'h2,  64'h80000,  19, 19};
      vecs[5] = '{16'd2, 8'hFF, 64'h1, 64'hC,  64'h300000, 21, 21};

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {59'd0, mem_rd_en, sys_in_valid, sys_done, sys_last, busy}, 64'd0);
      check("reset_addr", 64'(mem_rd_addr), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         check($sformatf("v%0d_rd_en", i), rd_m, vecs[i].exp_rd);
         check($sformatf("v%0d_in_valid", i), vld_m, vecs[i].exp_rd << ML);
         check($sformatf("v%0d_done", i), done_m, vecs[i].exp_done);
         check($sformatf("v%0d_last", i), last_m, 64'd1 << vecs[i].exp_last);
         check($sformatf("v%0d_busy", i), busy_m, (64'd1 << (vecs[i].exp_busy + 1)) - 64'd2);
         check($sformatf("v%0d_addr_err", i), 64'(addr_err), 64'd0);
`ifdef MEM_RD_PERF_CNT_EN
         if (i == 1) begin
            check("perf_stalls_stall", 64'(perf_stalls), 64'd1);
            check("perf_cycles_stall", 64'(perf_cycles), 64'd23);
         end
         if (i == 2) begin
            check("perf_cycles_zero", 64'(perf_cycles), 64'd2);
         end
`endif
      end

      // Starts while busy (cycles 5 and 21) are dropped; start at cycle 22 is accepted.
      rd_m = '0; done_m = '0; last_m = '0; busy_m = '0;
      addr3 = '0; addr23 = '0;
      for (int k = 0; k < 64; k++) begin
         start = (k == 0) || (k == 5) || (k == 21) || (k == 22);
         case (k)
            0:       begin num_row = 16'd3; base_addr = 8'hFE; end
            5:       begin num_row = 16'd7; base_addr = 8'h40; end
            21:      begin num_row = 16'd5; base_addr = 8'h60; end
            default: begin num_row = 16'd1; base_addr = 8'h55; end
         endcase
         rd_m[k]   = mem_rd_en;
         done_m[k] = sys_done;
         last_m[k] = sys_last;
         busy_m[k] = busy;
         if (k == 3)  addr3 = mem_rd_addr;
         if (k == 23) addr23 = mem_rd_addr;
         @(posedge clk); #1;
      end
      start = 1'b0;
      exp_b = '0;
      for (int b = 1; b <= 41; b++) if (b != 22) exp_b |= 64'd1 << b;
      check("b2b_rd_en", rd_m, (64'd1 << 1) | (64'd1 << 2) | (64'd1 << 3) | (64'd1 << 23));
      check("b2b_wrap_addr", 64'(addr3), 64'h00);
      check("b2b_second_addr", 64'(addr23), 64'h55);
      check("b2b_done", done_m, (64'h7 << 19) | (64'd1 << 41));
      check("b2b_last", last_m, (64'd1 << 21) | (64'd1 << 41));
      check("b2b_busy", busy_m, exp_b);
`ifdef MEM_RD_PERF_CNT_EN
      check("perf_cycles_b2b", 64'(perf_cycles), 64'd20);
      check("perf_stalls_b2b", 64'(perf_stalls), 64'd0);
`endif

      // Asynchronous reset while rows are in flight.
      num_row = 16'd4; base_addr = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_rd_en", {62'd0, mem_rd_en, busy}, 64'h3);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset_outputs",
            {59'd0, mem_rd_en, sys_in_valid, sys_done, sys_last, busy}, 64'd0);
      check("async_reset_addr", 64'(mem_rd_addr), 64'd0);
`ifdef MEM_RD_PERF_CNT_EN
      check("async_reset_perf", {16'd0, perf_stalls, perf_cycles}, 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      rd_m = '0;
      for (int k = 0; k < 40; k++) begin
         if (mem_rd_en || sys_in_valid || sys_done || sys_last || busy) rd_m[k] = 1'b1;
         @(posedge clk); #1;
      end
      check("post_reset_quiet", rd_m, 64'd0);

      run_vec(vecs[0]);
      check("recover_rd_en", rd_m, vecs[0].exp_rd);
      check("recover_done", done_m, vecs[0].exp_done);
      check("recover_last", last_m, 64'd1 << vecs[0].exp_last);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
